// File: rtl/pll_lock_supervisor_if.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor_if
// Signal bundle between the PLL lock supervisor and its surroundings (rPLL,
// reconfiguration requester, HDMI pipeline reset/status consumers).
//
//   lock       PLL LOCK, asynchronous to clkin            (into supervisor)
//   cfg_sel    requested configuration index              (into supervisor)
//   cfg_req    level reconfiguration request              (into supervisor)
//   cfg_ack    one-cycle request-accepted pulse           (from supervisor)
//   pll_reset  rPLL RESET, active high                    (from supervisor)
//   idsel      rPLL IDSEL                                 (from supervisor)
//   fbdsel     rPLL FBDSEL                                (from supervisor)
//   odsel      rPLL ODSEL                                 (from supervisor)
//   locked     qualified lock                             (from supervisor)
//   sys_rstn   active-low system reset                    (from supervisor)
//   err        retry budget exhausted                     (from supervisor)
//   lock_lost  sticky: lock dropped while running         (from supervisor)
//   retries    timeouts since the last successful lock    (from supervisor)
//
// master = supervisor side, slave = environment side.
// -----------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
    parameter int NUM_CFG   = 2,
    parameter int MAX_RETRY = 4
);
    localparam int SEL_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int RET_W = $clog2(MAX_RETRY + 1);

    logic             lock;
    logic [SEL_W-1:0] cfg_sel;
    logic             cfg_req;
    logic             cfg_ack;
    logic             pll_reset;
    logic [5:0]       idsel;
    logic [5:0]       fbdsel;
    logic [5:0]       odsel;
    logic             locked;
    logic             sys_rstn;
    logic             err;
    logic             lock_lost;
    logic [RET_W-1:0] retries;

    modport master (
        input  lock, cfg_sel, cfg_req,
        output cfg_ack, pll_reset, idsel, fbdsel, odsel,
               locked, sys_rstn, err, lock_lost, retries
    );

    modport slave (
        output lock, cfg_sel, cfg_req,
        input  cfg_ack, pll_reset, idsel, fbdsel, odsel,
               locked, sys_rstn, err, lock_lost, retries
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives a Gowin rPLL in dynamic-divider mode: pulses its RESET, selects the
// IDSEL/FBDSEL/ODSEL codes from a configuration table, qualifies LOCK with a
// timeout/retry budget and releases the system reset once lock is stable.
//
// Ports:
//   clkin   reference clock; every register runs on it
//   resetn  asynchronous active-low reset
//   bus     pll_lock_supervisor_if.master (lock, cfg_* handshake, rPLL
//           controls, locked/sys_rstn/err/lock_lost/retries status)
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int                    NUM_CFG       = 2,
    parameter int                    DEFAULT_CFG   = 0,
    parameter logic [6*NUM_CFG-1:0]  IDSEL_TABLE   = {NUM_CFG{6'd0}},
    parameter logic [6*NUM_CFG-1:0]  FBDSEL_TABLE  = {NUM_CFG{6'd0}},
    parameter logic [6*NUM_CFG-1:0]  ODSEL_TABLE   = {NUM_CFG{6'd0}},
    parameter int                    RST_CYCLES    = 16,
    parameter int                    LOCK_TIMEOUT  = 27000,
    parameter int                    STABLE_CYCLES = 2700,
    parameter int                    MAX_RETRY     = 4
) (
    input  logic                     clkin,
    input  logic                     resetn,
    pll_lock_supervisor_if.master    bus
);
    localparam int SEL_W   = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int RET_W   = $clog2(MAX_RETRY + 1);
    localparam int TAB_N   = 1 << SEL_W;
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_ERROR
    } state_t;

    // Table is widened to every code cfg_sel can carry; indices past NUM_CFG
    // alias the default entry, so an out-of-range request needs no compare.
    logic [5:0] id_tab [TAB_N];
    logic [5:0] fb_tab [TAB_N];
    logic [5:0] od_tab [TAB_N];

    for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
        localparam int SRC = (gi < NUM_CFG) ? gi : DEFAULT_CFG;
        assign id_tab[gi] = IDSEL_TABLE[6*SRC +: 6];
        assign fb_tab[gi] = FBDSEL_TABLE[6*SRC +: 6];
        assign od_tab[gi] = ODSEL_TABLE[6*SRC +: 6];
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic             lost_q, lost_d;
    logic             ack_q, ack_d;
    logic             pll_reset_q, pll_reset_d;
    logic             run_q, run_d;
    logic             err_q, err_d;
    logic [5:0]       idsel_q, idsel_d;
    logic [5:0]       fbdsel_q, fbdsel_d;
    logic [5:0]       odsel_q, odsel_d;
    logic             lock_meta_q, lock_s_q;
    logic             accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retries_d = retries_q;
        lost_d    = lost_q;
        ack_d     = 1'b0;
        idsel_d   = idsel_q;
        fbdsel_d  = fbdsel_q;
        odsel_d   = odsel_q;
        accept    = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retries_d = retries_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = (retries_d == RET_W'(MAX_RETRY)) ? S_ERROR : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                // Any dropout restarts qualification from scratch.
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                // A pending request takes priority over a simultaneous lock loss.
                if (bus.cfg_req) begin
                    accept = 1'b1;
                end else if (!lock_s_q) begin
                    lost_d  = 1'b1;
                    state_d = S_RESET_PLL;
                end
            end
            S_ERROR: begin
                cnt_d = '0;
                if (bus.cfg_req) begin
                    accept = 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            ack_d     = 1'b1;
            idsel_d   = id_tab[bus.cfg_sel];
            fbdsel_d  = fb_tab[bus.cfg_sel];
            odsel_d   = od_tab[bus.cfg_sel];
            lost_d    = 1'b0;
            retries_d = '0;
            state_d   = S_RESET_PLL;
            cnt_d     = '0;
        end

        // Outputs are decoded from the next state so they change on the
        // transition edge itself.
        pll_reset_d = (state_d == S_RESET_PLL);
        run_d       = (state_d == S_RUN);
        err_d       = (state_d == S_ERROR);
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retries_q   <= '0;
            lost_q      <= 1'b0;
            ack_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            idsel_q     <= IDSEL_TABLE[6*DEFAULT_CFG +: 6];
            fbdsel_q    <= FBDSEL_TABLE[6*DEFAULT_CFG +: 6];
            odsel_q     <= ODSEL_TABLE[6*DEFAULT_CFG +: 6];
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            lost_q      <= lost_d;
            ack_q       <= ack_d;
            pll_reset_q <= pll_reset_d;
            run_q       <= run_d;
            err_q       <= err_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            lock_meta_q <= bus.lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign bus.cfg_ack   = ack_q;
    assign bus.pll_reset = pll_reset_q;
    assign bus.idsel     = idsel_q;
    assign bus.fbdsel    = fbdsel_q;
    assign bus.odsel     = odsel_q;
    assign bus.locked    = run_q;
    assign bus.sys_rstn  = run_q;
    assign bus.err       = err_q;
    assign bus.lock_lost = lost_q;
    assign bus.retries   = retries_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed scenarios followed by randomized lock/request traffic. Each cycle
// the stimulus process advances a phase/timestamp reference model and queues
// the expected output vector; an independent monitor pops and compares after
// every rising edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;
    localparam int NUM_CFG = 2;
    localparam int DEF_CFG = 0;
    localparam int RST_C   = 4;
    localparam int TMO_C   = 20;
    localparam int STB_C   = 8;
    localparam int MAXR    = 2;

    // Entry 0 / entry 1 codes as the model sees them.
    localparam int ID_T [2] = '{17, 34};
    localparam int FB_T [2] = '{9, 50};
    localparam int OD_T [2] = '{3, 12};

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_QUAL   = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    typedef struct packed {
        logic       ack;
        logic       prst;
        logic [5:0] id;
        logic [5:0] fb;
        logic [5:0] od;
        logic       lk;
        logic       srn;
        logic       er;
        logic       lost;
        logic [1:0] rt;
    } obs_t;

    logic clk;
    logic resetn;
    bit   rst_drive;
    int   ncheck = 0;
    int   nerr   = 0;
    obs_t exp_q[$];

    pll_lock_supervisor_if #(.NUM_CFG(NUM_CFG), .MAX_RETRY(MAXR)) bus ();

    pll_lock_supervisor #(
        .NUM_CFG      (NUM_CFG),
        .DEFAULT_CFG  (DEF_CFG),
        .IDSEL_TABLE  ({6'd34, 6'd17}),
        .FBDSEL_TABLE ({6'd50, 6'd9}),
        .ODSEL_TABLE  ({6'd12, 6'd3}),
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TMO_C),
        .STABLE_CYCLES(STB_C),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clkin (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_phase;
    int m_age;      // edges completed in the current phase
    int m_retry;
    int m_sel;
    bit m_lost;
    bit m_ack;
    bit lk_hist[$]; // lock samples of the two previous edges

    function automatic void model_reset();
        m_phase = PH_PLLRST;
        m_age   = 0;
        m_retry = 0;
        m_sel   = DEF_CFG;
        m_lost  = 1'b0;
        m_ack   = 1'b0;
        lk_hist = '{1'b0, 1'b0};
    endfunction

    function automatic void enter(input int ph);
        m_phase = ph;
        m_age   = 0;
    endfunction

    function automatic void model_edge(input bit lk, input bit rq, input int sl);
        bit seen = lk_hist[0];  // LOCK reaches the decision two edges late
        m_ack = 1'b0;
        if (m_phase == PH_PLLRST) begin
            m_age++;
            if (m_age == RST_C) enter(PH_WAIT);
        end else if (m_phase == PH_WAIT) begin
            if (seen) enter(PH_QUAL);
            else begin
                m_age++;
                if (m_age == TMO_C) begin
                    m_retry++;
                    enter(m_retry == MAXR ? PH_FAIL : PH_PLLRST);
                end
            end
        end else if (m_phase == PH_QUAL) begin
            if (!seen) enter(PH_WAIT);
            else begin
                m_age++;
                if (m_age == STB_C) begin
                    m_retry = 0;
                    enter(PH_RUN);
                end
            end
        end else begin
            if (rq) begin
                m_ack   = 1'b1;
                m_sel   = (sl < NUM_CFG) ? sl : DEF_CFG;
                m_lost  = 1'b0;
                m_retry = 0;
                enter(PH_PLLRST);
            end else if (m_phase == PH_RUN && !seen) begin
                m_lost = 1'b1;
                enter(PH_PLLRST);
            end
        end
        void'(lk_hist.pop_front());
        lk_hist.push_back(lk);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.ack  = m_ack;
        o.prst = (m_phase == PH_PLLRST);
        o.id   = 6'(ID_T[m_sel]);
        o.fb   = 6'(FB_T[m_sel]);
        o.od   = 6'(OD_T[m_sel]);
        o.lk   = (m_phase == PH_RUN);
        o.srn  = (m_phase == PH_RUN);
        o.er   = (m_phase == PH_FAIL);
        o.lost = m_lost;
        o.rt   = 2'(m_retry);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.ack  = bus.cfg_ack;
        o.prst = bus.pll_reset;
        o.id   = bus.idsel;
        o.fb   = bus.fbdsel;
        o.od   = bus.odsel;
        o.lk   = bus.locked;
        o.srn  = bus.sys_rstn;
        o.er   = bus.err;
        o.lost = bus.lock_lost;
        o.rt   = bus.retries;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ack=%0b prst=%0b id=%0d fb=%0d od=%0d locked=%0b sys_rstn=%0b err=%0b lost=%0b retries=%0d",
                         o.ack, o.prst, o.id, o.fb, o.od, o.lk, o.srn, o.er, o.lost, o.rt);
    endfunction

    // ---------------- monitor ----------------
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_obs();
                ncheck++;
                if (a !== e) begin
                    nerr++;
                    $display("FAIL outputs t=%0t got {%s} exp {%s}", $time, fmt(a), fmt(e));
                end else if (a.ack) begin
                    $display("cfg_ack t=%0t: id=%0d fb=%0d od=%0d", $time, a.id, a.fb, a.od);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit lk, input bit rq, input int sl);
        @(negedge clk);
        resetn      = rst_drive;
        bus.lock    = lk;
        bus.cfg_req = rq;
        bus.cfg_sel = 1'(sl);
        if (rst_drive) model_edge(lk, rq, sl);
        else           model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic run_until(input bit lk, input bit rq, input int sl, input int ph,
                             input int age, input int budget, input string what);
        int n = 0;
        while (!(m_phase == ph && (age < 0 || m_age == age))) begin
            if (n == budget) begin
                ncheck++;
                nerr++;
                $display("FAIL %s: bound %0d cycles expired, phase=%0d want=%0d", what, budget, m_phase, ph);
                return;
            end
            cyc(lk, rq, sl);
            n++;
        end
        $display("%s: reached phase %0d after %0d cycles", what, ph, n);
    endtask

    task automatic run_ack(input bit lk, input int sl, input int budget, input string what);
        int n = 0;
        do begin
            if (n == budget) begin
                ncheck++;
                nerr++;
                $display("FAIL %s: no acceptance within %0d cycles", what, budget);
                return;
            end
            cyc(lk, 1'b1, sl);
            n++;
        end while (!m_ack);
        $display("%s: request accepted after %0d cycles (sel=%0d)", what, n, sl);
    endtask

    task automatic async_reset(input string what);
        obs_t e, a;
        @(negedge clk);
        #1;
        resetn    = 1'b0;
        rst_drive = 1'b0;
        model_reset();
        e = model_out();
        exp_q.push_back(e);
        #1;
        a = dut_obs();
        ncheck++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s async reset: got {%s} exp {%s}", what, fmt(a), fmt(e));
        end else begin
            $display("%s: asynchronous reset values present before any edge", what);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit lk_r, rq_r;
        int sl_r;
        resetn      = 1'b0;
        rst_drive   = 1'b0;
        bus.lock    = 1'b0;
        bus.cfg_req = 1'b0;
        bus.cfg_sel = '0;
        model_reset();

        // Power-up: reset values, 4-cycle PLL reset, lock 5 cycles later.
        repeat (3) cyc(0, 0, 0);
        rst_drive = 1'b1;
        run_until(0, 0, 0, PH_WAIT, -1, 10, "s1 pll_reset pulse");
        repeat (5) cyc(0, 0, 0);
        run_until(1, 0, 0, PH_RUN, -1, 40, "s1 first lock");
        repeat (3) cyc(1, 0, 0);

        // Lock loss in RUN, then a dropout during qualification.
        run_until(0, 0, 0, PH_PLLRST, -1, 6, "s4 lock loss");
        run_until(0, 0, 0, PH_WAIT, -1, 10, "s4 pll_reset pulse");
        run_until(1, 0, 0, PH_QUAL, 5, 40, "s2 stable count 5");
        cyc(0, 0, 0);
        run_until(1, 0, 0, PH_RUN, -1, 40, "s2 relock");
        repeat (3) cyc(1, 0, 0);

        // Reconfigure to entry 1 from RUN.
        run_ack(1, 1, 10, "s5 accept in run");
        run_until(1, 0, 0, PH_RUN, -1, 40, "s5 relock");
        // Lock loss and request meet in the same RUN cycle.
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        run_ack(0, 0, 5, "s5 request beats lock loss");
        cyc(0, 0, 0);

        // Request held while the retry budget runs out; accepted in ERROR.
        run_until(0, 1, 1, PH_FAIL, -1, 120, "s3 held request to error");
        run_ack(0, 1, 3, "s5 accept from error");
        cyc(0, 0, 0);
        run_until(0, 0, 0, PH_FAIL, -1, 120, "s3 second error");
        repeat (6) cyc(0, 0, 0);
        run_ack(0, 1, 3, "s3 error exit");

        // Asynchronous reset mid-wait restores entry 0.
        run_until(0, 0, 0, PH_WAIT, 10, 40, "s6 wait count 10");
        async_reset("s6");
        repeat (2) cyc(0, 0, 0);
        rst_drive = 1'b1;
        run_until(0, 0, 0, PH_WAIT, -1, 10, "s6 restart pulse");
        run_until(1, 0, 0, PH_RUN, -1, 40, "s6 relock");

        // Randomized traffic.
        lk_r = 1'b1;
        rq_r = 1'b0;
        sl_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) lk_r = !lk_r;
            if (rq_r && m_ack) rq_r = 1'b0;
            else if (!rq_r && $urandom_range(0, 79) == 0) begin
                rq_r = 1'b1;
                sl_r = int'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 599) == 0) begin
                async_reset("random");
                repeat (2) cyc(lk_r, 1'b0, 0);
                rst_drive = 1'b1;
            end
            cyc(lk_r, rq_r, sl_r);
        end

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises a Gowin rPLL run in dynamic-divider mode on the board reference clock (27 MHz on Tang Nano 9K).
- Drives PLL RESET and the IDSEL/FBDSEL/ODSEL buses from a parameter table of NUM_CFG configurations, so HDMI resolutions can be switched at run time.
- Qualifies LOCK, with timeout, retry and error handling.
- Produces a system reset release and a sticky lock-loss flag for the HDMI pipeline.

Parameters:
NUM_CFG, 2, number of PLL configurations in the tables
DEFAULT_CFG, 0, configuration applied after reset
IDSEL_TABLE, {NUM_CFG{6'd0}}, packed 6-bit IDSEL codes; entry i at bits [6i+5:6i]; forwarded unmodified
FBDSEL_TABLE, {NUM_CFG{6'd0}}, packed 6-bit FBDSEL codes, same layout
ODSEL_TABLE, {NUM_CFG{6'd0}}, packed 6-bit ODSEL codes, same layout
RST_CYCLES, 16, PLL reset pulse length in clkin cycles (>=1)
LOCK_TIMEOUT, 27000, cycles to wait for lock before a retry
STABLE_CYCLES, 2700, consecutive synchronised-lock cycles required before release
MAX_RETRY, 4, timeouts tolerated before the ERROR state (>=1)

Ports:
clkin  in  1  reference clock; all logic runs on it
resetn  in  1  asynchronous active-low reset
lock  in  1  PLL LOCK output, asynchronous to clkin
cfg_sel  in  max(1,$clog2(NUM_CFG))  requested configuration index
cfg_req  in  1  level request for reconfiguration
cfg_ack  out  1  one-cycle pulse: request accepted
pll_reset  out  1  to rPLL RESET (active high)
idsel  out  6  to rPLL IDSEL
fbdsel  out  6  to rPLL FBDSEL
odsel  out  6  to rPLL ODSEL
locked  out  1  qualified lock
sys_rstn  out  1  active-low system reset, synchronous to clkin
err  out  1  retry budget exhausted
lock_lost  out  1  sticky: lock dropped while in RUN
retries  out  $clog2(MAX_RETRY+1)  timeouts since the last successful lock

Behaviour:
General
- All outputs are registered and change on the clock edge that performs the state transition.
- lock passes through a 2-flop synchroniser (lock_s) before any use.

Reset values (resetn=0, asynchronous)
- State RESET_PLL, counter 0, pll_reset=1.
- idsel/fbdsel/odsel = DEFAULT_CFG entries.
- locked=0, sys_rstn=0, cfg_ack=0, err=0, lock_lost=0, retries=0, synchroniser cleared.

States
- RESET_PLL: pll_reset=1. Counter increments; at RST_CYCLES-1 go to WAIT_LOCK with counter cleared. pll_reset is therefore high exactly RST_CYCLES cycles.
- WAIT_LOCK: pll_reset=0, counter increments.
  - lock_s=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 -> retries+1. If the new value equals MAX_RETRY -> ERROR, else -> RESET_PLL.
- STABLE: counter counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK, counter cleared; retries unchanged.
  - Count reaches STABLE_CYCLES-1 -> RUN; retries cleared.
- RUN: locked=1, sys_rstn=1.
  - lock_s=0 -> lock_lost=1, go to RESET_PLL; locked and sys_rstn drop on that edge.
- ERROR: err=1, pll_reset=0, locked=0, sys_rstn=0. Exit only via an accepted cfg_req or resetn.

Reconfiguration
- cfg_req is sampled only in RUN and ERROR. In other states it is held off and not acknowledged; the requester keeps it high.
- Acceptance:
  - cfg_ack=1 for one cycle.
  - sel buses load the cfg_sel entries on the same edge.
  - Clears err, lock_lost and retries.
  - Go to RESET_PLL.
- cfg_sel >= NUM_CFG selects DEFAULT_CFG.
- The requester must drop cfg_req after cfg_ack. If it is still high when RUN is next reached, it is accepted again.
- Lock loss and cfg_req in the same RUN cycle: the request wins; lock_lost stays 0.
- sel buses change only on reset or on acceptance, never while pll_reset=0 in a locked state.

Counters
- Saturating-free: every count is bounded by a state transition.
- Counter width = $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1).

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, NUM_CFG=2, DEFAULT_CFG=0.

1. Release resetn; raise lock 5 cycles after pll_reset falls -> pll_reset high exactly 4 cycles. locked/sys_rstn rise 2+8 cycles after the lock edge (±1 for the sync edge). retries=0.
2. In STABLE, drop lock for 1 cycle at stable count 5 -> no release; after lock returns, a full 8 stable cycles are required before locked=1.
3. lock held at 0 -> two 4-cycle pll_reset pulses separated by 20-cycle waits. After the second timeout: err=1, retries=2, pll_reset stays 0.
4. In RUN, drop lock -> lock_lost=1, locked/sys_rstn=0 three cycles after the lock edge. A new 4-cycle pll_reset pulse follows, then relock; lock_lost stays 1.
5. In RUN, cfg_sel=1, cfg_req=1 -> cfg_ack single pulse. idsel/fbdsel/odsel show entry 1 on the same edge; lock_lost cleared; pll_reset pulse. With cfg_req held through ERROR after scenario 3, the request is accepted and err clears.
6. Assert resetn low during WAIT_LOCK counter=10 -> all outputs at reset values immediately (asynchronously). After release, the sequence restarts from RESET_PLL with sel = entry 0.
